// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU execute sequencer: opcodes, instruction field positions,
// sequencer states and the legal-opcode check.
package alu_ctrl_pkg;

  localparam int unsigned FLD_W = 6;
  localparam int unsigned IMM_W = 16;

  // Instruction field positions (LSB of each field)
  localparam int unsigned OPC_LSB   = 26;
  localparam int unsigned RDST1_LSB = 20;
  localparam int unsigned RSRC1_LSB = 14;
  localparam int unsigned RSRC2_LSB = 8;
  localparam int unsigned RDST2_LSB = 2;
  localparam int unsigned IMM_LSB   = 0;

  localparam logic [5:0] OP_MOVI  = 6'b000000;
  localparam logic [5:0] OP_MOVR  = 6'b000001;
  localparam logic [5:0] OP_LOAD  = 6'b000010;
  localparam logic [5:0] OP_STORE = 6'b000011;
  localparam logic [5:0] OP_ADD   = 6'b000100;
  localparam logic [5:0] OP_SUB   = 6'b000101;
  localparam logic [5:0] OP_NEG   = 6'b000110;
  localparam logic [5:0] OP_MUL   = 6'b000111;
  localparam logic [5:0] OP_DIV   = 6'b001000;
  localparam logic [5:0] OP_OR    = 6'b001001;
  localparam logic [5:0] OP_XOR   = 6'b001010;
  localparam logic [5:0] OP_NAND  = 6'b001011;
  localparam logic [5:0] OP_NOR   = 6'b001100;
  localparam logic [5:0] OP_XNOR  = 6'b001101;
  localparam logic [5:0] OP_NOT   = 6'b001110;
  localparam logic [5:0] OP_LLSH  = 6'b001111;
  localparam logic [5:0] OP_LRSH  = 6'b010000;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StExec,
    StWait,
    StWb1,
    StWb2,
    StErr
  } state_e;

  // LOAD/STORE live elsewhere, so they count as illegal here.
  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_MOVI) || (op == OP_MOVR) || ((op >= OP_ADD) && (op <= OP_LRSH));
  endfunction

endpackage

// File: rtl/alu_instr_fields.sv
// Combinational split of a 32-bit instruction word into its fields plus decode flags.
//   i_instr      : raw instruction word
//   o_opcode     : [31:26]        o_rdst1 : [25:20]     o_rsrc1 : [19:14]
//   o_rsrc2      : [13:8]         o_rdst2 : [7:2]       o_imm   : [15:0]
//   o_is_movi/o_is_movr/o_is_mul : opcode class flags
//   o_is_legal   : opcode is handled by the sequencer
module alu_instr_fields
  import alu_ctrl_pkg::*;
(
  input  logic [31:0]      i_instr,
  output logic [FLD_W-1:0] o_opcode,
  output logic [FLD_W-1:0] o_rdst1,
  output logic [FLD_W-1:0] o_rdst2,
  output logic [FLD_W-1:0] o_rsrc1,
  output logic [FLD_W-1:0] o_rsrc2,
  output logic [IMM_W-1:0] o_imm,
  output logic             o_is_movi,
  output logic             o_is_movr,
  output logic             o_is_mul,
  output logic             o_is_legal
);

  assign o_opcode   = i_instr[OPC_LSB +: FLD_W];
  assign o_rdst1    = i_instr[RDST1_LSB +: FLD_W];
  assign o_rdst2    = i_instr[RDST2_LSB +: FLD_W];
  assign o_rsrc1    = i_instr[RSRC1_LSB +: FLD_W];
  assign o_rsrc2    = i_instr[RSRC2_LSB +: FLD_W];
  assign o_imm      = i_instr[IMM_LSB +: IMM_W];
  assign o_is_movi  = (o_opcode == OP_MOVI);
  assign o_is_movr  = (o_opcode == OP_MOVR);
  assign o_is_mul   = (o_opcode == OP_MUL);
  assign o_is_legal = is_legal_op(o_opcode);

endmodule

// File: rtl/alu_exec_sequencer.sv
// Multi-cycle execute controller: accepts one instruction, reads operands from the register
// file, launches the ALU, waits for completion (with timeout) and writes back one result word
// (two for MUL). All outputs are registered.
//   i_clk, i_reset            : clock, asynchronous active-high reset
//   i_instr_valid/o_instr_ready, i_instr : instruction handshake (accepted in idle only)
//   o_rf_raddr1/2, i_rf_rdata1/2         : register-file read ports (combinational data)
//   o_alu_start/op/a/b, i_alu_done, i_alu_result : ALU launch and completion
//   o_rf_we/waddr/wdata                  : register-file write port
//   o_busy, o_done, o_err_illegal, o_err_timeout : status and one-cycle event pulses
module alu_exec_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned REG_AW         = 6,
  parameter int unsigned DW             = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_instr_valid,
  output logic              o_instr_ready,
  input  logic [31:0]       i_instr,
  output logic [REG_AW-1:0] o_rf_raddr1,
  output logic [REG_AW-1:0] o_rf_raddr2,
  input  logic [DW-1:0]     i_rf_rdata1,
  input  logic [DW-1:0]     i_rf_rdata2,
  output logic              o_alu_start,
  output logic [5:0]        o_alu_op,
  output logic [DW-1:0]     o_alu_a,
  output logic [DW-1:0]     o_alu_b,
  input  logic              i_alu_done,
  input  logic [2*DW-1:0]   i_alu_result,
  output logic              o_rf_we,
  output logic [REG_AW-1:0] o_rf_waddr,
  output logic [DW-1:0]     o_rf_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_illegal,
  output logic              o_err_timeout
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The WAIT cycle holding CntLast is the abort cycle; its pulses are set one edge earlier.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntPre  = CntW'(TIMEOUT_CYCLES - 2);

  logic [FLD_W-1:0] w_opcode, w_rdst1, w_rdst2, w_rsrc1, w_rsrc2;
  logic [IMM_W-1:0] w_imm;
  logic             w_is_movi, w_is_movr, w_is_mul, w_is_legal;

  alu_instr_fields u_fields (
    .i_instr    (i_instr),
    .o_opcode   (w_opcode),
    .o_rdst1    (w_rdst1),
    .o_rdst2    (w_rdst2),
    .o_rsrc1    (w_rsrc1),
    .o_rsrc2    (w_rsrc2),
    .o_imm      (w_imm),
    .o_is_movi  (w_is_movi),
    .o_is_movr  (w_is_movr),
    .o_is_mul   (w_is_mul),
    .o_is_legal (w_is_legal)
  );

  state_e            r_state;
  logic [5:0]        r_op;
  logic [REG_AW-1:0] r_rdst1, r_rdst2;
  logic              r_is_mul, r_is_movr;
  logic [2*DW-1:0]   r_result;
  logic [CntW-1:0]   r_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_op          <= '0;
      r_rdst1       <= '0;
      r_rdst2       <= '0;
      r_is_mul      <= 1'b0;
      r_is_movr     <= 1'b0;
      r_result      <= '0;
      r_cnt         <= '0;
      o_instr_ready <= 1'b1;
      o_rf_raddr1   <= '0;
      o_rf_raddr2   <= '0;
      o_alu_start   <= 1'b0;
      o_alu_op      <= '0;
      o_alu_a       <= '0;
      o_alu_b       <= '0;
      o_rf_we       <= 1'b0;
      o_rf_waddr    <= '0;
      o_rf_wdata    <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err_illegal <= 1'b0;
      o_err_timeout <= 1'b0;
    end else begin
      // Pulses and write port default to idle each cycle; states below re-assert them.
      o_alu_start   <= 1'b0;
      o_rf_we       <= 1'b0;
      o_rf_waddr    <= '0;
      o_rf_wdata    <= '0;
      o_done        <= 1'b0;
      o_err_illegal <= 1'b0;
      o_err_timeout <= 1'b0;

      unique case (r_state)
        StIdle: begin
          if (i_instr_valid) begin
            o_instr_ready <= 1'b0;
            o_busy        <= 1'b1;
            r_op          <= w_opcode;
            r_rdst1       <= REG_AW'(w_rdst1);
            r_rdst2       <= REG_AW'(w_rdst2);
            r_is_mul      <= w_is_mul;
            r_is_movr     <= w_is_movr;
            o_rf_raddr1   <= REG_AW'(w_rsrc1);
            o_rf_raddr2   <= REG_AW'(w_rsrc2);
            if (!w_is_legal) begin
              o_err_illegal <= 1'b1;
              o_done        <= 1'b1;
              r_state       <= StErr;
            end else if (w_is_movi) begin
              r_result   <= (2*DW)'(w_imm);
              o_rf_we    <= 1'b1;
              o_rf_waddr <= REG_AW'(w_rdst1);
              o_rf_wdata <= DW'(w_imm);
              o_done     <= 1'b1;
              r_state    <= StWb1;
            end else begin
              r_state <= StRead;
            end
          end
        end

        StRead: begin
          if (r_is_movr) begin
            r_result   <= (2*DW)'(i_rf_rdata1);
            o_rf_we    <= 1'b1;
            o_rf_waddr <= r_rdst1;
            o_rf_wdata <= i_rf_rdata1;
            o_done     <= 1'b1;
            r_state    <= StWb1;
          end else begin
            o_alu_op    <= r_op;
            o_alu_a     <= i_rf_rdata1;
            o_alu_b     <= i_rf_rdata2;
            o_alu_start <= 1'b1;
            r_state     <= StExec;
          end
        end

        StExec: begin
          r_cnt   <= '0;
          r_state <= StWait;
          // Degenerate single-cycle timeout: the first WAIT cycle is already the abort cycle.
          if (CntLast == '0) begin
            o_err_timeout <= 1'b1;
            o_done        <= 1'b1;
          end
        end

        StWait: begin
          if (r_cnt == CntLast) begin
            o_instr_ready <= 1'b1;
            o_busy        <= 1'b0;
            r_state       <= StIdle;
          end else if (i_alu_done) begin
            r_result   <= i_alu_result;
            o_rf_we    <= 1'b1;
            o_rf_waddr <= r_rdst1;
            o_rf_wdata <= i_alu_result[DW-1:0];
            o_done     <= !r_is_mul;
            r_state    <= StWb1;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
            if (r_cnt == CntPre) begin
              o_err_timeout <= 1'b1;
              o_done        <= 1'b1;
            end
          end
        end

        StWb1: begin
          if (r_is_mul) begin
            o_rf_we    <= 1'b1;
            o_rf_waddr <= r_rdst2;
            o_rf_wdata <= r_result[2*DW-1:DW];
            o_done     <= 1'b1;
            r_state    <= StWb2;
          end else begin
            o_instr_ready <= 1'b1;
            o_busy        <= 1'b0;
            r_state       <= StIdle;
          end
        end

        StWb2, StErr: begin
          o_instr_ready <= 1'b1;
          o_busy        <= 1'b0;
          r_state       <= StIdle;
        end

        default: begin
          o_instr_ready <= 1'b1;
          o_busy        <= 1'b0;
          r_state       <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_exec_sequencer.md
Name: alu_exec_sequencer

Overview:
- Multi-cycle execute controller for the 16-bit ALU datapath.
- Accepts one 32-bit instruction word per handshake and reads source operands from the register file.
- Launches the ALU operation, waits for completion (multi-cycle MUL/DIV), then writes back one result word, or two for MUL.
- Sits between instruction issue and the ALU/register file; it owns the register-file write port.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles in WAIT before abort with err_timeout.
- REG_AW, 6, register-file address width (matches 6-bit register fields).
- DW, 16, datapath word width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept (IDLE only).
- instr  in  32  [31:26] opcode, [25:20] rdst1, [19:14] rsrc1, [13:8] rsrc2, [7:2] rdst2, [15:0] immediate.
- rf_raddr1  out  REG_AW  read address A (rsrc1).
- rf_raddr2  out  REG_AW  read address B (rsrc2).
- rf_rdata1  in  DW  combinational read data A.
- rf_rdata2  in  DW  combinational read data B.
- alu_start  out  1  one-cycle launch pulse.
- alu_op  out  6  opcode held stable from start to done.
- alu_a  out  DW  operand A (rsrc1 data), held stable.
- alu_b  out  DW  operand B (rsrc2 data), held stable.
- alu_done  in  1  result valid pulse.
- alu_result  in  2*DW  ALU result; upper half meaningful for MUL only.
- rf_we  out  1  register write enable.
- rf_waddr  out  REG_AW  write address.
- rf_wdata  out  DW  write data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on the final write-back or abort.
- err_illegal  out  1  one-cycle pulse for an unsupported opcode.
- err_timeout  out  1  one-cycle pulse when ALU completion times out.

Behaviour:
- Reset (async): state IDLE. All outputs 0 except instr_ready=1. Latched instruction, operands, result and timeout counter cleared.
- Reset mid-operation: immediate abort; no write is issued and no done pulse.
- Opcodes:
  - MOVI 000000: rdst1 <= imm.
  - MOVR 000001: rdst1 <= R[rsrc1].
  - ALU ops 000100..010000 (ADD, SUB, NEG, MUL, DIV, OR, XOR, NAND, NOR, XNOR, NOT, LLSH, LRSH).
  - All others are illegal, including 000010/000011 (LOAD/STORE, not handled here).
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr and dispatch:
  - illegal -> ERR;
  - MOVI -> WB1 with result=imm;
  - otherwise -> READ.
- READ (1 cycle): drive raddr1/raddr2 and capture rdata1/rdata2 at the clock edge.
  - MOVR -> WB1 with result=rdata1.
  - Otherwise -> EXEC.
- EXEC (1 cycle): alu_start=1; alu_op/a/b valid. -> WAIT; timeout counter cleared.
- WAIT:
  - On alu_done, capture alu_result -> WB1. alu_done in the same cycle as start is not possible (start is registered); minimum ALU latency is 1.
  - Else increment the counter. When the counter reaches TIMEOUT_CYCLES-1 without done, pulse err_timeout and done -> IDLE. No write.
- WB1: rf_we=1, waddr=rdst1, wdata=result[15:0]. MUL -> WB2; else pulse done -> IDLE.
- WB2 (MUL only): rf_we=1, waddr=rdst2, wdata=result[31:16]; pulse done -> IDLE. If rdst1==rdst2, both writes occur in order and the upper half wins.
- ERR (1 cycle): pulse err_illegal and done -> IDLE. No register read or write.
- Latency from accept to final write: MOVI 1; MOVR 2; single-result ALU op 3+L (L = ALU cycles to done); MUL 4+L.
- alu_done outside WAIT is ignored. instr_valid outside IDLE is ignored; no accept.
- Throughput: one instruction in flight; the next can be accepted the cycle after done.
- alu_op/a/b hold the last values in idle states; rf_waddr/wdata are don't-care when rf_we=0 but are driven 0.

Decomposition:
- Package alu_ctrl_pkg:
  - opcode localparams (OP_MOVI … OP_LRSH);
  - field bit-position constants;
  - state enum {IDLE, READ, EXEC, WAIT, WB1, WB2, ERR};
  - function is_legal_op(op).
- One natural sub-module, alu_instr_fields: combinational split of the 32-bit word into opcode, rdst1, rdst2, rsrc1, rsrc2, imm, plus flags is_movi, is_movr, is_mul, is_legal.

Test Plan:
- MOVI: instr={000000,…,imm=16'hBEEF}, valid 1 cycle -> next cycle rf_we=1, waddr=rdst1, wdata=16'hBEEF, done=1; no alu_start.
- ADD: R3=16'h0005 (rsrc1), R4=16'h0007 (rsrc2), ALU done 2 cycles after start with 16'h000C -> single write of R[rdst1]=16'h000C; accept-to-write 5 cycles.
- MUL: a=16'h1234, b=16'h0100, result 32'h00123400; rdst1=6, rdst2=7 -> WB1 writes R6=16'h3400, next cycle WB2 writes R7=16'h0012, done on the WB2 cycle.
- Illegal opcode 000011 -> err_illegal and done pulse one cycle after accept; rf_we stays 0; instr_ready high the following cycle.
- Timeout: DIV launched, alu_done never asserted, TIMEOUT_CYCLES=8 -> err_timeout on the 8th WAIT cycle, no write, return to IDLE.
- Reset asserted during WAIT of MUL -> outputs clear asynchronously, no WB1/WB2 write, instr_ready=1 after reset release; a stray alu_done after reset is ignored.
